spi_xfer_ctrl: RTL and testbench

- Transaction controller for the SPI master.
- Accepts a start request with TX word, length and divide ratio.
- Sequences chip-select setup, a gated and divided spi_clk burst of exactly xfer_len pulses, MSB-first shifting of MOSI/MISO, and chip-select hold.
- Returns the received word with a done pulse.
- Sits between the host-side register/command logic and the SPI pins.

---
 rtl/spi_xfer_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI master transaction sequencer
// cs_n setup, gated divided spi_clk burst, MSB-first shift, cs_n hold.
//
// Ports:
//   clk, rst           system clock, async active-high reset
//   start              request, taken only in IDLE with xfer_len != 0
//   xfer_len           bits to move (clamped to SPI_MAXLEN)
//   clk_div            spi_clk half-period in clk cycles (0 acts as 1)
//   tx_data            transmit word, right-justified
//   cpol               idle clock level (only with SPI_CPOL_EN)
//   busy, done         in-progress flag, one-cycle completion pulse
//   rx_data            received word, right-justified, held until next done
//   spi_clk/mosi/miso/cs_n  pin side
//
// Optional macro SPI_CPOL_EN adds the cpol input (mode 0 / mode 2).
module spi_xfer_ctrl #(
  parameter int SPI_MAXLEN = 16,
  parameter int DIV_W      = 16,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(SPI_MAXLEN):0] xfer_len,
  input  logic [DIV_W-1:0]            clk_div,
  input  logic [SPI_MAXLEN-1:0]       tx_data,
`ifdef SPI_CPOL_EN
  input  logic                        cpol,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [SPI_MAXLEN-1:0]       rx_data,
  output logic                        spi_clk,
  output logic                        spi_mosi,
  input  logic                        spi_miso,
  output logic                        spi_cs_n
);

  localparam int LW = $clog2(SPI_MAXLEN) + 1;
  localparam int IW = $clog2(SPI_MAXLEN);

  typedef enum logic [2:0] {
    IDLE, SETUP, CLK_LO, CLK_HI, HOLD
  } state_t;

  state_t state, nxt;

  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      h_q;
  logic [LW-1:0]         bit_q, bit_d;
  logic [SPI_MAXLEN-1:0] tx_q;
  logic [SPI_MAXLEN-1:0] rx_sh, rx_sh_d;
  logic [SPI_MAXLEN-1:0] rx_d;
  logic                  busy_d, done_d;
  logic                  clk_d, mosi_d, cs_n_d;
  logic                  pol_d;

  logic                  accept;
  logic                  cnt_zero;
  logic [LW-1:0]         n_in;
  logic [DIV_W-1:0]      h_in;

  assign accept   = (state == IDLE) && start && (xfer_len != '0);
  assign cnt_zero = (cnt_q == '0);
  assign n_in     = (xfer_len > LW'(SPI_MAXLEN)) ?
                    LW'(SPI_MAXLEN) : xfer_len;
  assign h_in     = (clk_div == '0) ? DIV_W'(1) : clk_div;

`ifdef SPI_CPOL_EN
  logic pol_q;
  assign pol_d = accept ? cpol : pol_q;
`else
  assign pol_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept)   nxt = SETUP;
      SETUP:   if (cnt_zero) nxt = CLK_LO;
      CLK_LO:  if (cnt_zero) nxt = CLK_HI;
      CLK_HI:  if (cnt_zero)
                 nxt = (bit_q == '0) ? HOLD : CLK_LO;
      HOLD:    if (cnt_zero) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    // counter reloads on every state change, counts down otherwise
    cnt_d = cnt_q - DIV_W'(1);
    if (nxt != state) begin
      unique case (nxt)
        SETUP:          cnt_d = DIV_W'(CS_SETUP - 1);
        CLK_LO, CLK_HI: cnt_d = h_q - DIV_W'(1);
        HOLD:           cnt_d = DIV_W'(CS_HOLD - 1);
        default:        cnt_d = '0;
      endcase
    end else if (state == IDLE) begin
      cnt_d = '0;
    end

    bit_d   = bit_q;
    mosi_d  = spi_mosi;
    rx_sh_d = rx_sh;
    unique case (1'b1)
      accept: begin
        bit_d   = n_in - LW'(1);
        mosi_d  = tx_data[IW'(n_in - LW'(1))];
        rx_sh_d = '0;
      end
      (state == CLK_HI && nxt == CLK_LO): begin
        bit_d  = bit_q - LW'(1);
        mosi_d = tx_q[IW'(bit_q - LW'(1))];
      end
      (state == CLK_HI && nxt == HOLD): begin
        mosi_d = 1'b0;
      end
      (state == CLK_LO && nxt == CLK_HI): begin
        rx_sh_d = {rx_sh[SPI_MAXLEN-2:0], spi_miso};
      end
      default: ;
    endcase

    done_d = (state == HOLD) && (nxt == IDLE);
    rx_d   = done_d ? rx_sh : rx_data;
    busy_d = (nxt != IDLE);
    cs_n_d = (nxt == IDLE);
    // leading edge is always the CLK_LO -> CLK_HI step
    clk_d  = (nxt == CLK_HI) ^ pol_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      h_q      <= DIV_W'(1);
      bit_q    <= '0;
      tx_q     <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      rx_sh    <= rx_sh_d;
      rx_data  <= rx_d;
      busy     <= busy_d;
      done     <= done_d;
      spi_clk  <= clk_d;
      spi_mosi <= mosi_d;
      spi_cs_n <= cs_n_d;
      if (accept) begin
        h_q  <= h_in;
        tx_q <= tx_data;
      end
    end
  end

`ifdef SPI_CPOL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pol_q <= 1'b0;
    else     pol_q <= pol_d;
  end
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: scoreboard bench for spi_xfer_ctrl
// Stimulus pushes expected transfers; a monitor checks each done.
module tb_spi_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  xfer_len = '0;
  logic [15:0] clk_div = '0;
  logic [15:0] tx_data = '0;
  logic        busy, done, spi_clk, spi_mosi, spi_miso, spi_cs_n;
  logic [15:0] rx_data;
`ifdef SPI_CPOL_EN
  logic        cpol = 1'b0;
`endif

  spi_xfer_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .xfer_len (xfer_len),
    .clk_div  (clk_div),
    .tx_data  (tx_data),
`ifdef SPI_CPOL_EN
    .cpol     (cpol),
`endif
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  always #5 clk = ~clk;

  // Loopback or a mode-0 slave that shifts out slave_word MSB first
  logic        loop_en = 1'b1;
  logic [15:0] slave_word = '0;
  logic [15:0] slave_sh = '0;
  assign spi_miso = loop_en ? spi_mosi : slave_sh[15];
  always @(negedge spi_cs_n) slave_sh <= slave_word;
  always @(negedge spi_clk)
    if (!spi_cs_n) slave_sh <= {slave_sh[14:0], 1'b0};

  typedef struct {
    logic [15:0] rx;
    int          busy_len;
    int          rises;
    logic [15:0] mosi;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_done = 0;
  int   done_total = 0;
  int   busy_cnt = 0;
  int   rises = 0;
  int   hi_run = 0;
  int   last_gap = -1;
  int   bad_clk = 0;
  logic [15:0] mosi_word = '0;
  logic prev_clk = 1'b0;
  logic prev_cs = 1'b1;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt  = 0;
      rises     = 0;
      mosi_word = '0;
      prev_clk  = 1'b0;
      prev_cs   = 1'b1;
      hi_run    = 0;
    end else begin
      if (busy) busy_cnt++;
      if (spi_clk && !prev_clk) begin
        if (spi_cs_n) bad_clk++;
        else begin
          rises++;
          mosi_word = {mosi_word[14:0], spi_mosi};
        end
      end
      if (spi_cs_n) hi_run++;
      else if (prev_cs) begin
        last_gap = hi_run;
        hi_run   = 0;
      end
      prev_clk = spi_clk;
      prev_cs  = spi_cs_n;
      if (done) begin
        done_total++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done rx %h", rx_data);
        end else begin
          e = q.pop_front();
          chk("rx_data", rx_data, e.rx);
          chk("busy_len", busy_cnt, e.busy_len);
          chk("clk_rises", rises, e.rises);
          chk("mosi_bits", mosi_word, e.mosi);
          if (e.gap >= 0) chk("cs_high_gap", last_gap, e.gap);
        end
        busy_cnt  = 0;
        rises     = 0;
        mosi_word = '0;
      end
    end
  end

  // Called on a negedge; leaves start high across one posedge
  task automatic issue(input logic [15:0] tx, input int len,
                       input int div, input logic [15:0] rx_exp,
                       input int gap, input bit push);
    exp_t e;
    int n, h;
    n = (len > 16) ? 16 : len;
    h = (div < 1) ? 1 : div;
    if (push) begin
      e.rx       = rx_exp;
      e.busy_len = 2 + 2 * h * n + 2;
      e.rises    = n;
      e.mosi     = (n == 16) ? tx : (tx & ((16'h1 << n) - 16'h1));
      e.gap      = gap;
      q.push_back(e);
      exp_done++;
    end
    tx_data  = tx;
    xfer_len = 5'(len);
    clk_div  = 16'(div);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      if (done) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout got 0 exp 1");
  endtask

  initial begin
    int bad, r, to;
    logic pc;
    repeat (2) @(negedge clk);
    chk("reset_state",
        {busy, done, spi_clk, spi_mosi, spi_cs_n, rx_data},
        {4'b0000, 1'b1, 16'h0000});
    rst = 1'b0;
    @(negedge clk);

    issue(16'h00A5, 8, 2, 16'h00A5, -1, 1);
    wait_done();

    @(negedge clk);
    loop_en    = 1'b0;
    slave_word = 16'h1234;
    issue(16'hFFFF, 16, 1, 16'h1234, -1, 1);
    wait_done();
    @(negedge clk);
    loop_en = 1'b1;

    issue(16'h00FF, 0, 1, 16'h0000, -1, 0);
    bad = 0;
    repeat (10) begin
      if (busy || !spi_cs_n || done) bad++;
      @(negedge clk);
    end
    chk("len0_idle", bad, 0);

    issue(16'hBEEF, 20, 1, 16'hBEEF, -1, 1);
    wait_done();
    @(negedge clk);

    issue(16'h0009, 4, 0, 16'h0009, -1, 1);
    wait_done();
    @(negedge clk);

    issue(16'h005A, 8, 1, 16'h005A, -1, 1);
    repeat (5) @(negedge clk);
    tx_data  = 16'h00FF;
    xfer_len = 5'd4;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done();
    @(negedge clk);

    issue(16'h0003, 2, 1, 16'h0003, -1, 1);
    wait_done();
    issue(16'h0002, 2, 1, 16'h0002, 1, 1);
    wait_done();
    @(negedge clk);

    issue(16'h00C3, 8, 2, 16'h0000, -1, 0);
    r  = 0;
    to = 0;
    pc = spi_clk;
    while (r < 5 && to < 500) begin
      @(negedge clk);
      if (spi_clk && !pc) r++;
      pc = spi_clk;
      to++;
    end
    chk("reach_bit3_hi", r, 5);
    rst = 1'b1;
    #1;
    chk("mid_reset",
        {busy, done, spi_clk, spi_mosi, spi_cs_n, rx_data},
        {4'b0000, 1'b1, 16'h0000});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h0081, 8, 1, 16'h0081, -1, 1);
    wait_done();
    repeat (5) @(negedge clk);

    chk("done_count", done_total, exp_done);
    chk("queue_empty", q.size(), 0);
    chk("clk_while_cs_high", bad_clk, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
